// File: rtl/spart_driver_if.sv
// Bus-strobe signals between the spart_driver (master) and the SPART (slave).
// The bidirectional databus stays a plain inout on the driver.
interface spart_driver_if;
   // One access per cycle with iocs=1; iorw=1 reads, iorw=0 writes.
   // The slave drives data only when iocs=1 and iorw=1.
   // No ready signal exists, so every access completes in its single cycle.
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;

   modport master (output iocs, output iorw, output ioaddr);
   modport slave  (input  iocs, input  iorw, input  ioaddr);
endinterface

// File: rtl/spart_driver.sv
// Processor stand-in for the SPART: programs the baud divisor from br_cfg,
// polls status, reads each received byte and echoes it back through the tx buffer.
module spart_driver #(
   parameter logic [15:0] DIV_4800  = 16'h028A,
   parameter logic [15:0] DIV_9600  = 16'h0144,
   parameter logic [15:0] DIV_19200 = 16'h00A1,
   parameter logic [15:0] DIV_38400 = 16'h0050
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [1:0]     br_cfg,
   spart_driver_if.master bus,
   inout  wire  [7:0]     databus,
   output logic [7:0]     echo_cnt,
   output logic [7:0]     last_byte
);

   typedef enum logic [2:0] {
      INIT     = 3'd0,
      CFG_LOW  = 3'd1,
      CFG_HIGH = 3'd2,
      POLL_RX  = 3'd3,
      READ_RX  = 3'd4,
      POLL_TX  = 3'd5,
      WRITE_TX = 3'd6
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [1:0]  cfg_q;
   logic [15:0] div;
   logic        acc_cs;
   logic        acc_rw;
   logic [1:0]  acc_addr;
   logic        drive;
   logic [7:0]  wdata;

   always_comb begin
      div = DIV_4800;
      case (cfg_q)
         2'b00:   div = DIV_4800;
         2'b01:   div = DIV_9600;
         2'b10:   div = DIV_19200;
         default: div = DIV_38400;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= INIT;
      else     state <= next_state;
   end

   // A switch change outranks rda so the divisor is rewritten before the next byte.
   always_comb begin
      next_state = state;
      case (state)
         INIT:     next_state = CFG_LOW;
         CFG_LOW:  next_state = CFG_HIGH;
         CFG_HIGH: next_state = POLL_RX;
         POLL_RX: begin
            if (br_cfg != cfg_q)   next_state = CFG_LOW;
            else if (databus[0])   next_state = READ_RX;
            else                   next_state = POLL_RX;
         end
         READ_RX:  next_state = POLL_TX;
         POLL_TX:  next_state = databus[1] ? WRITE_TX : POLL_TX;
         WRITE_TX: next_state = POLL_RX;
         default:  next_state = INIT;
      endcase
   end

   always_comb begin
      acc_cs   = 1'b0;
      acc_rw   = 1'b1;
      acc_addr = 2'b00;
      drive    = 1'b0;
      wdata    = 8'h00;
      case (state)
         CFG_LOW: begin
            acc_cs = 1'b1; acc_rw = 1'b0; acc_addr = 2'b10;
            drive  = 1'b1; wdata  = div[7:0];
         end
         CFG_HIGH: begin
            acc_cs = 1'b1; acc_rw = 1'b0; acc_addr = 2'b11;
            drive  = 1'b1; wdata  = div[15:8];
         end
         POLL_RX, POLL_TX: begin
            acc_cs = 1'b1; acc_addr = 2'b01;
         end
         READ_RX: begin
            acc_cs = 1'b1; acc_addr = 2'b00;
         end
         WRITE_TX: begin
            acc_cs = 1'b1; acc_rw = 1'b0; acc_addr = 2'b00;
            drive  = 1'b1; wdata  = last_byte;
         end
         default: ;
      endcase
   end

   assign bus.iocs   = acc_cs;
   assign bus.iorw   = acc_rw;
   assign bus.ioaddr = acc_addr;
   assign databus    = drive ? wdata : 8'hzz;

   always_ff @(posedge clk) begin
      if (rst) begin
         echo_cnt  <= 8'h00;
         last_byte <= 8'h00;
         cfg_q     <= br_cfg;
      end else begin
         case (state)
            INIT:     cfg_q <= br_cfg;
            POLL_RX:  if (br_cfg != cfg_q) cfg_q <= br_cfg;
            READ_RX:  last_byte <= databus;
            WRITE_TX: echo_cnt <= echo_cnt + 8'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spart_driver.sv
// Directed-plus-random bench for spart_driver: a responder plays the SPART,
// a baud-rate model supplies divisors and counters track the expected echo state.
module tb_spart_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] br_cfg = 2'b01;
   wire  [7:0] databus;
   logic [7:0] echo_cnt;
   logic [7:0] last_byte;

   logic [7:0] status_val = 8'h02;
   logic [7:0] rx_val = 8'h00;

   int         vectors = 0;
   int         fails = 0;
   logic [7:0] exp_cnt = 8'h00;
   logic [7:0] exp_last = 8'h00;
   logic [1:0] cur_cfg = 2'b01;
   logic [7:0] wrap_start;

   spart_driver_if bus ();

   spart_driver dut (
      .clk       (clk),
      .rst       (rst),
      .br_cfg    (br_cfg),
      .bus       (bus),
      .databus   (databus),
      .echo_cnt  (echo_cnt),
      .last_byte (last_byte)
   );

   always #5 clk = ~clk;

   // SPART side: answers reads only, so the bus is otherwise left to the driver.
   assign databus = (bus.iocs && bus.iorw) ?
                    ((bus.ioaddr == 2'b00) ? rx_val : status_val) : 8'hzz;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Divisor from the baud rate: 50 MHz / (16 * baud) - 1, rounded down.
   function automatic logic [15:0] div_for(input logic [1:0] cfg);
      int baud;
      baud = 4800 << cfg;
      return 16'(50_000_000 / (16 * baud) - 1);
   endfunction

   task automatic access(input logic rw, input logic [1:0] addr, input logic [7:0] wd,
                         input string tag);
      @(negedge clk);
      chk({12'd0, bus.iocs, bus.iorw, bus.ioaddr}, {12'd0, 1'b1, rw, addr}, tag);
      if (!rw) chk({8'd0, databus}, {8'd0, wd}, {tag, ".data"});
   endtask

   task automatic expect_cfg(input logic [1:0] cfg);
      logic [15:0] d;
      d = div_for(cfg);
      access(1'b0, 2'b10, d[7:0], "cfg_low");
      access(1'b0, 2'b11, d[15:8], "cfg_high");
   endtask

   task automatic do_reset(input logic [1:0] cfg);
      rst = 1'b1;
      br_cfg = cfg;
      @(negedge clk);
      chk({12'd0, bus.iocs, bus.iorw, bus.ioaddr}, 16'h0004, "init_bus");
      chk({8'd0, echo_cnt}, 16'h0000, "rst_echo_cnt");
      chk({8'd0, last_byte}, 16'h0000, "rst_last_byte");
      rst = 1'b0;
      exp_cnt = 8'h00;
      exp_last = 8'h00;
      cur_cfg = cfg;
      status_val = 8'h02;
      expect_cfg(cfg);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) access(1'b1, 2'b01, 8'h00, "idle_poll");
   endtask

   task automatic echo_body(input logic [7:0] b, input int tbr_wait,
                            input logic cfg_en, input logic [1:0] new_cfg);
      access(1'b1, 2'b00, 8'h00, "rx_read");
      rx_val = b;
      status_val = 8'h00;
      for (int i = 0; i <= tbr_wait; i++) begin
         access(1'b1, 2'b01, 8'h00, "tx_poll");
         if (i == 0) begin
            chk({8'd0, last_byte}, {8'd0, b}, "last_byte");
            if (cfg_en) br_cfg = new_cfg;
         end
         if (i == tbr_wait) status_val = 8'h02;
      end
      access(1'b0, 2'b00, b, "tx_write");
      exp_cnt = exp_cnt + 8'd1;
      exp_last = b;
   endtask

   task automatic echo(input logic [7:0] b, input int tbr_wait);
      access(1'b1, 2'b01, 8'h00, "rx_poll");
      chk({8'd0, echo_cnt}, {8'd0, exp_cnt}, "echo_cnt");
      chk({8'd0, last_byte}, {8'd0, exp_last}, "last_byte_hold");
      status_val = 8'h01;
      echo_body(b, tbr_wait, 1'b0, 2'b00);
   endtask

   task automatic reconfig(input logic [1:0] nc);
      access(1'b1, 2'b01, 8'h00, "rx_poll_cfg");
      br_cfg = nc;
      if (nc != cur_cfg) expect_cfg(nc);
      cur_cfg = nc;
   endtask

   initial begin
      // Power-up with 9600 baud selected
      do_reset(2'b01);

      // Idle polling with rda=0
      idle(20);
      chk({8'd0, echo_cnt}, 16'h0000, "idle_echo_cnt");

      // Single echo with three tbr=0 polls
      echo(8'hA5, 3);
      access(1'b1, 2'b01, 8'h00, "post_echo_poll");
      chk({8'd0, echo_cnt}, 16'h0001, "echo_cnt_one");
      chk({8'd0, last_byte}, 16'h00A5, "last_byte_a5");

      // Switch change in POLL_RX outranks a pending rda
      access(1'b1, 2'b01, 8'h00, "poll_before_cfg");
      br_cfg = 2'b11;
      status_val = 8'h03;
      expect_cfg(2'b11);
      cur_cfg = 2'b11;
      access(1'b1, 2'b01, 8'h00, "poll_after_cfg");
      echo_body(8'($urandom), 1, 1'b0, 2'b00);

      // Switch change during POLL_TX: byte echoed first, then reconfiguration
      access(1'b1, 2'b01, 8'h00, "rx_poll");
      status_val = 8'h01;
      echo_body(8'($urandom), 2, 1'b1, 2'b00);
      access(1'b1, 2'b01, 8'h00, "poll_sees_cfg");
      expect_cfg(2'b00);
      cur_cfg = 2'b00;
      idle(3);
      chk({8'd0, echo_cnt}, {8'd0, exp_cnt}, "echo_cnt_after_cfg");

      // 256 random echoes wrap echo_cnt back to its starting value
      wrap_start = exp_cnt;
      for (int n = 0; n < 256; n++) begin
         if (n % 64 == 63) reconfig(2'($urandom));
         echo(8'($urandom), $urandom_range(0, 3));
         idle($urandom_range(0, 2));
      end
      access(1'b1, 2'b01, 8'h00, "post_wrap_poll");
      chk({8'd0, echo_cnt}, {8'd0, wrap_start}, "echo_cnt_wrap");
      chk({8'd0, last_byte}, {8'd0, exp_last}, "last_byte_wrap");

      // Reset asserted during WRITE_TX aborts the echo
      access(1'b1, 2'b01, 8'h00, "rx_poll");
      status_val = 8'h01;
      access(1'b1, 2'b00, 8'h00, "rx_read");
      rx_val = 8'h3C;
      status_val = 8'h02;
      access(1'b1, 2'b01, 8'h00, "tx_poll");
      access(1'b0, 2'b00, 8'h3C, "tx_write");
      do_reset(2'($urandom));
      idle(3);
      chk({8'd0, echo_cnt}, 16'h0000, "echo_cnt_after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
